// File: rtl/boreal_csp_logvar_pkg.sv
// Shared types and helpers for the CSP log-variance feature extractor.
// Holds the data widths, the post-processing state encoding and the
// square / saturating-subtract helpers used by the top level.
package boreal_csp_pkg;

    localparam int CSP_W      = 24;   // CSP projection width (signed)
    localparam int FEAT_W     = 16;   // feature width, unsigned Q6.10
    localparam int LOG_FRAC_W = 10;   // fractional bits of the log2 feature
    localparam int LOG_ILOG_W = 6;    // integer bits of the log2 feature
    localparam int LOG_IN_W   = 48;   // log2 operand width
    localparam int SQ_W       = 47;   // width of an unsigned CSP square

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POW  = 3'd1,
        ST_MSQ  = 3'd2,
        ST_LOG  = 3'd3,
        ST_OUT  = 3'd4
    } logvar_state_e;

    // Square of a signed CSP sample; (-2^23)^2 = 2^46 still fits in 47 bits.
    function automatic logic [SQ_W-1:0] csp_square(input logic signed [CSP_W-1:0] v);
        logic signed [LOG_IN_W-1:0] p;
        p = LOG_IN_W'(v) * LOG_IN_W'(v);
        return SQ_W'(p);
    endfunction

    // a - b clamped at zero, used to keep the variance non-negative.
    function automatic logic [SQ_W-1:0] sat_sub(input logic [SQ_W-1:0] a,
                                                input logic [SQ_W-1:0] b);
        logic [SQ_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/boreal_csp_logvar_if.sv
// Sample/feature bus between the CSP filter, the log-variance extractor
// and the classifier. The producer side uses master, the extractor slave.
interface boreal_csp_logvar_if;
    import boreal_csp_pkg::*;

    logic                     in_valid;
    logic signed [CSP_W-1:0]  in_v0;
    logic signed [CSP_W-1:0]  in_v1;
    logic                     clear;
    logic                     out_valid;
    logic [FEAT_W-1:0]        feat0;
    logic [FEAT_W-1:0]        feat1;
    logic [FEAT_W-1:0]        epoch_cnt;
    logic                     overrun;

    modport master (
        output in_valid, in_v0, in_v1, clear,
        input  out_valid, feat0, feat1, epoch_cnt, overrun
    );

    modport slave (
        input  in_valid, in_v0, in_v1, clear,
        output out_valid, feat0, feat1, epoch_cnt, overrun
    );

endinterface

// File: rtl/boreal_csp_logvar_log2.sv
// Combinational fixed-point log2: leading-one index gives the integer part,
// the ten bits directly below the leading one give the fraction (zero padded
// on the right for small operands). Operands 0 and 1 map to 0x0000.
module boreal_log2_q6_10
    import boreal_csp_pkg::*;
(
    input  logic [LOG_IN_W-1:0] val,
    output logic [FEAT_W-1:0]   feat
);

    logic [LOG_ILOG_W-1:0] ilog;
    logic [LOG_FRAC_W-1:0] frac;

    // Leading-one detection followed by mantissa alignment.
    always_comb begin
        ilog = '0;
        for (int i = 0; i < LOG_IN_W; i++) begin
            ilog = val[i] ? LOG_ILOG_W'(i) : ilog;
        end
        if (ilog >= LOG_ILOG_W'(LOG_FRAC_W)) begin
            frac = LOG_FRAC_W'(val >> (ilog - LOG_ILOG_W'(LOG_FRAC_W)));
        end else begin
            frac = LOG_FRAC_W'(val << (LOG_ILOG_W'(LOG_FRAC_W) - ilog));
        end
        if (val < LOG_IN_W'(2)) begin
            feat = '0;
        end else begin
            feat = {ilog, frac};
        end
    end

endmodule

// File: rtl/boreal_csp_logvar.sv
// Per-window log-power (or log-variance) feature extractor for two CSP
// projections. Samples are accumulated over 2^WIN_LOG2 samples; the closed
// window is snapshotted so accumulation continues while a small FSM turns
// the snapshot into two Q6.10 log2 features.
// Optional build macro: BOREAL_LOGVAR_MEAN_EN (subtract the squared mean,
// i.e. emit log2 of the variance instead of the mean square).
module boreal_csp_logvar
    import boreal_csp_pkg::*;
#(
    parameter int WIN_LOG2 = 8
)
(
    input  logic                clk,
    input  logic                rst,
    boreal_csp_logvar_if.slave  bus
);

    localparam int ACC_W = SQ_W + WIN_LOG2;

    logic [WIN_LOG2-1:0] sample_cnt;
    logic [ACC_W-1:0]    sq_acc0;
    logic [ACC_W-1:0]    sq_acc1;
    logic [ACC_W-1:0]    snap0;
    logic [ACC_W-1:0]    snap1;
    logic [SQ_W-1:0]     sq0;
    logic [SQ_W-1:0]     sq1;
    logic [SQ_W-1:0]     pow0;
    logic [SQ_W-1:0]     pow1;
    logic [FEAT_W-1:0]   log0;
    logic [FEAT_W-1:0]   log1;
    logic                close_win;
    logvar_state_e       state;

    logic                out_valid_q;
    logic [FEAT_W-1:0]   feat0_q;
    logic [FEAT_W-1:0]   feat1_q;
    logic [FEAT_W-1:0]   epoch_q;
    logic                overrun_q;

`ifdef BOREAL_LOGVAR_MEAN_EN
    localparam int SUM_W = CSP_W + WIN_LOG2;
    logic signed [SUM_W-1:0] sum0;
    logic signed [SUM_W-1:0] sum1;
    logic signed [SUM_W-1:0] ssnap0;
    logic signed [SUM_W-1:0] ssnap1;
    logic signed [CSP_W-1:0] mean0;
    logic signed [CSP_W-1:0] mean1;
`endif

    assign sq0       = csp_square(bus.in_v0);
    assign sq1       = csp_square(bus.in_v1);
    // clear has priority: a sample arriving with clear never closes a window.
    assign close_win = bus.in_valid & ~bus.clear & (&sample_cnt);

    // Window accumulation and snapshot of the closing window.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
            sq_acc0    <= '0;
            sq_acc1    <= '0;
            snap0      <= '0;
            snap1      <= '0;
`ifdef BOREAL_LOGVAR_MEAN_EN
            sum0       <= '0;
            sum1       <= '0;
            ssnap0     <= '0;
            ssnap1     <= '0;
`endif
        end else if (bus.clear) begin
            sample_cnt <= '0;
            sq_acc0    <= '0;
            sq_acc1    <= '0;
`ifdef BOREAL_LOGVAR_MEAN_EN
            sum0       <= '0;
            sum1       <= '0;
`endif
        end else if (bus.in_valid) begin
            if (close_win) begin
                sample_cnt <= '0;
                sq_acc0    <= '0;
                sq_acc1    <= '0;
`ifdef BOREAL_LOGVAR_MEAN_EN
                sum0       <= '0;
                sum1       <= '0;
`endif
                // A busy post-processor keeps its snapshot; this window is lost.
                if (state == ST_IDLE) begin
                    snap0  <= sq_acc0 + ACC_W'(sq0);
                    snap1  <= sq_acc1 + ACC_W'(sq1);
`ifdef BOREAL_LOGVAR_MEAN_EN
                    ssnap0 <= sum0 + SUM_W'(bus.in_v0);
                    ssnap1 <= sum1 + SUM_W'(bus.in_v1);
`endif
                end
            end else begin
                sample_cnt <= sample_cnt + WIN_LOG2'(1);
                sq_acc0    <= sq_acc0 + ACC_W'(sq0);
                sq_acc1    <= sq_acc1 + ACC_W'(sq1);
`ifdef BOREAL_LOGVAR_MEAN_EN
                sum0       <= sum0 + SUM_W'(bus.in_v0);
                sum1       <= sum1 + SUM_W'(bus.in_v1);
`endif
            end
        end
    end

    boreal_log2_q6_10 u_log0 (.val({1'b0, pow0}), .feat(log0));
    boreal_log2_q6_10 u_log1 (.val({1'b0, pow1}), .feat(log1));

    // Post-processing FSM and registered feature outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pow0        <= '0;
            pow1        <= '0;
            out_valid_q <= 1'b0;
            feat0_q     <= '0;
            feat1_q     <= '0;
            epoch_q     <= '0;
            overrun_q   <= 1'b0;
`ifdef BOREAL_LOGVAR_MEAN_EN
            mean0       <= '0;
            mean1       <= '0;
`endif
        end else begin
            if (close_win && (state != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            out_valid_q <= 1'b0;
            if (bus.clear) begin
                state   <= ST_IDLE;
                epoch_q <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (close_win) begin
                            state <= ST_POW;
                        end
                    end
                    ST_POW: begin
                        pow0 <= SQ_W'(snap0 >> WIN_LOG2);
                        pow1 <= SQ_W'(snap1 >> WIN_LOG2);
`ifdef BOREAL_LOGVAR_MEAN_EN
                        mean0 <= CSP_W'(ssnap0 >>> WIN_LOG2);
                        mean1 <= CSP_W'(ssnap1 >>> WIN_LOG2);
                        state <= ST_MSQ;
`else
                        state <= ST_LOG;
`endif
                    end
`ifdef BOREAL_LOGVAR_MEAN_EN
                    ST_MSQ: begin
                        pow0  <= sat_sub(pow0, csp_square(mean0));
                        pow1  <= sat_sub(pow1, csp_square(mean1));
                        state <= ST_LOG;
                    end
`endif
                    ST_LOG: begin
                        // Features land together with the pulse seen during OUT.
                        feat0_q     <= log0;
                        feat1_q     <= log1;
                        out_valid_q <= 1'b1;
                        epoch_q     <= epoch_q + FEAT_W'(1);
                        state       <= ST_OUT;
                    end
                    ST_OUT: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.feat0     = feat0_q;
    assign bus.feat1     = feat1_q;
    assign bus.epoch_cnt = epoch_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_boreal_csp_logvar.sv
// Self-checking bench for boreal_csp_logvar. A WIN_LOG2=4 instance runs the
// directed and random windows; a WIN_LOG2=2 instance exercises back-to-back
// windows for the overrun behaviour. Expected features come from an
// arithmetic model of mean square / variance and log2.
module tb_boreal_csp_logvar;
    import boreal_csp_pkg::*;

    localparam int N = 16;
`ifdef BOREAL_LOGVAR_MEAN_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst;

    boreal_csp_logvar_if bus  ();
    boreal_csp_logvar_if bus2 ();

    boreal_csp_logvar #(.WIN_LOG2(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    boreal_csp_logvar #(.WIN_LOG2(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_epoch = 0;
    int ov1 = 0;
    int ov2 = 0;
    int w0 [N];
    int w1 [N];

    // Count output pulses of both instances.
    always @(posedge clk) begin
        if (bus.out_valid === 1'b1)  ov1 <= ov1 + 1;
        if (bus2.out_valid === 1'b1) ov2 <= ov2 + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference log2 in Q6.10 from plain integer arithmetic.
    function automatic longint ref_log2(input longint x);
        longint t;
        int il;
        longint fr;
        if (x < 2) return 0;
        t = x;
        il = 0;
        while (t > 1) begin
            t = t >> 1;
            il++;
        end
        if (il >= 10) fr = (x >> (il - 10)) & 64'h3FF;
        else          fr = (x << (10 - il)) & 64'h3FF;
        return (longint'(il) << 10) | fr;
    endfunction

    // Reference feature of one window: log2 of mean square, or of variance.
    function automatic longint ref_feat(input int w [N]);
        longint s, sq, pw, m;
        s = 0;
        sq = 0;
        for (int i = 0; i < N; i++) begin
            sq += longint'(w[i]) * longint'(w[i]);
            s  += longint'(w[i]);
        end
        pw = sq / N;
`ifdef BOREAL_LOGVAR_MEAN_EN
        m = s / N;
        if (s < 0 && (s % N) != 0) m = m - 1;
        pw = pw - m * m;
        if (pw < 0) pw = 0;
`else
        m = s;
`endif
        return ref_log2(pw);
    endfunction

    task automatic drive(input bit v, input int a, input int b, input bit c);
        bus.in_valid = v;
        bus.in_v0    = 24'(a);
        bus.in_v1    = 24'(b);
        bus.clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input bit v, input int a, input int b, input bit c);
        bus2.in_valid = v;
        bus2.in_v0    = 24'(a);
        bus2.in_v1    = 24'(b);
        bus2.clear    = c;
        @(posedge clk);
        #1;
    endtask

    // Feed w0/w1 as one window and check latency, features, count, pulse width.
    task automatic run_window(input string tag);
        int k;
        int found;
        int ov_before;
        longint e0, e1;
        ov_before = ov1;
        e0 = ref_feat(w0);
        e1 = ref_feat(w1);
        for (int i = 0; i < N; i++) drive(1'b1, w0[i], w1[i], 1'b0);
        exp_epoch++;
        bus.in_valid = 1'b0;
        k = 0;
        while (k < 10 && bus.out_valid !== 1'b1) begin
            drive(1'b0, 0, 0, 1'b0);
            k++;
        end
        found = (bus.out_valid === 1'b1) ? k : -1;
        // The pulse occupies cycle T+LAT, i.e. LAT-1 edges after the accepting edge.
        check({tag, ".lat"},   64'(found), 64'(LAT - 1));
        check({tag, ".feat0"}, 64'(bus.feat0), 64'(e0));
        check({tag, ".feat1"}, 64'(bus.feat1), 64'(e1));
        check({tag, ".epoch"}, 64'(bus.epoch_cnt), 64'(exp_epoch));
        drive(1'b0, 0, 0, 1'b0);
        check({tag, ".pulse"}, 64'(bus.out_valid), 64'(0));
        check({tag, ".hold"},  64'(bus.feat0), 64'(e0));
        check({tag, ".npulse"}, 64'(ov1 - ov_before), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sh;
        int closes;
        int last_acc;
        int exp_ep2;
        int exp_ovr;

        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.in_v0 = '0;  bus.in_v1 = '0;  bus.clear = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_v0 = '0; bus2.in_v1 = '0; bus2.clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", 64'(bus.out_valid), 64'(0));
        check("rst.feat0",     64'(bus.feat0), 64'(0));
        check("rst.feat1",     64'(bus.feat1), 64'(0));
        check("rst.epoch",     64'(bus.epoch_cnt), 64'(0));
        check("rst.overrun",   64'(bus.overrun), 64'(0));
        check("rst.overrun2",  64'(bus2.overrun), 64'(0));
        rst = 1'b0;
        drive(1'b0, 0, 0, 1'b0);

        for (int i = 0; i < N; i++) begin w0[i] = 0; w1[i] = 0; end
        run_window("zero");

        for (int i = 0; i < N; i++) begin w0[i] = 256; w1[i] = -256; end
        run_window("const");

        for (int i = 0; i < N; i++) begin w0[i] = (i % 2 == 0) ? 4096 : -4096; w1[i] = 3072; end
        run_window("alt");

        for (int i = 0; i < N; i++) begin w0[i] = -8388608; w1[i] = 8388607; end
        run_window("extreme");

        for (int r = 0; r < 6; r++) begin
            sh = int'($urandom_range(0, 22));
            for (int i = 0; i < N; i++) begin
                w0[i] = int'($signed(24'($urandom))) >>> sh;
                w1[i] = int'($signed(24'($urandom))) >>> (22 - sh);
            end
            run_window("rand");
        end

        // clear after 5 samples, with a sample in the same cycle.
        for (int i = 0; i < 5; i++) drive(1'b1, 8000000, -8000000, 1'b0);
        drive(1'b1, 8000000, 8000000, 1'b1);
        exp_epoch = 0;
        check("clr.epoch", 64'(bus.epoch_cnt), 64'(0));
        for (int i = 0; i < N; i++) begin
            w0[i] = int'($signed(24'($urandom))) >>> 6;
            w1[i] = 100 + i;
        end
        run_window("postclr");
        check("clr.overrun", 64'(bus.overrun), 64'(0));

        // clear while the window is being post-processed: no pulse, count zeroed.
        begin
            int ov_b;
            for (int i = 0; i < N; i++) drive(1'b1, 5000, 7000, 1'b0);
            ov_b = ov1;
            drive(1'b0, 0, 0, 1'b1);
            repeat (6) drive(1'b0, 0, 0, 1'b0);
            exp_epoch = 0;
            check("clrpp.npulse", 64'(ov1 - ov_b), 64'(0));
            check("clrpp.epoch",  64'(bus.epoch_cnt), 64'(0));
        end

        // Back-to-back windows of 4 samples on the WIN_LOG2=2 instance.
        exp_ep2 = 0;
        exp_ovr = 0;
        last_acc = -100;
        closes = 0;
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 3) begin
                // Busy for LAT cycles after a close; a close inside that span is lost.
                if (i > last_acc + LAT) begin
                    exp_ep2++;
                    last_acc = i;
                end else begin
                    exp_ovr = 1;
                end
                closes++;
            end
            drive2(1'b1, int'($signed(24'($urandom))), int'($signed(24'($urandom))), 1'b0);
        end
        bus2.in_valid = 1'b0;
        repeat (8) drive2(1'b0, 0, 0, 1'b0);
        check("ovr.epoch",   64'(bus2.epoch_cnt), 64'(exp_ep2));
        check("ovr.npulse",  64'(ov2), 64'(exp_ep2));
        check("ovr.overrun", 64'(bus2.overrun), 64'(exp_ovr));
        check("ovr.closes",  64'(closes), 64'(3));
        drive2(1'b0, 0, 0, 1'b1);
        check("ovr.clr_keep", 64'(bus2.overrun), 64'(exp_ovr));
        check("ovr.clr_epoch", 64'(bus2.epoch_cnt), 64'(0));
        bus2.clear = 1'b0;
        rst = 1'b1;
        drive2(1'b0, 0, 0, 1'b0);
        rst = 1'b0;
        check("ovr.rst_clr", 64'(bus2.overrun), 64'(0));
        check("rst2.feat0",  64'(bus.feat0), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
